// File: rtl/req_encoder83_pkg.sv
// Shared constants and helpers for the 8-to-3 request encoder.
// Priority runs from the top bit down, matching the 3-8 decoder it pairs with.
package req_encoder83_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  function automatic logic [IDX_W-1:0] prio_idx(input logic [N_REQ-1:0] vec);
    logic [IDX_W-1:0] idx;
    idx = {IDX_W{1'b0}};
    // Ascending scan, so the last (highest) set bit wins.
    for (int i = 0; i < N_REQ; i++) begin
      if (vec[i]) begin
        idx = IDX_W'(i);
      end
    end
    return idx;
  endfunction

  function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    return {{(N_REQ-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/req_encoder83_if.sv
// Event-stream handshake: the encoder drives index/valid, the consumer drives ready.
interface req_encoder83_if;
  import req_encoder83_pkg::*;

  logic [IDX_W-1:0] out_idx;
  logic             out_valid;
  logic             out_ready;

  modport master (output out_idx, output out_valid, input out_ready);
  modport slave  (input out_idx, input out_valid, output out_ready);

endinterface

// File: rtl/req_encoder83_sync_edge_det.sv
// Vector 2-flop synchronizer plus delay flop; flags a rising edge for one cycle.
module sync_edge_det #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [N-1:0] din,
  output logic [N-1:0] edge_det
);

  logic [N-1:0] s1_r;
  logic [N-1:0] s2_r;
  logic [N-1:0] prv_r;

  // Synchronizer chain and previous-value flop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_r  <= {N{1'b0}};
      s2_r  <= {N{1'b0}};
      prv_r <= {N{1'b0}};
    end else begin
      s1_r  <= din;
      s2_r  <= s1_r;
      prv_r <= s2_r;
    end
  end

  assign edge_det = s2_r & ~prv_r;

endmodule

// File: rtl/req_encoder83.sv
// Sequential 8-to-3 priority encoder: rising request edges become a stream of
// 3-bit indices over a valid/ready handshake, with pending and overflow status.
module req_encoder83
  import req_encoder83_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [N_REQ-1:0]     req,
  input  logic                 clear,
  req_encoder83_if.master      evt,
  output logic [N_REQ-1:0]     pending,
  output logic                 ovf
);

  logic [N_REQ-1:0] edge_s;
  logic [N_REQ-1:0] ack_mask_s;
  logic [N_REQ-1:0] pending_next_s;
  logic             ovf_next_s;
  logic             hold_s;

  logic [N_REQ-1:0] pending_r;
  logic             ovf_r;
  logic [IDX_W-1:0] out_idx_r;
  logic             out_valid_r;

  sync_edge_det #(.N(N_REQ)) u_sync (
    .clk      (clk),
    .reset_n  (reset_n),
    .din      (req),
    .edge_det (edge_s)
  );

  // Next pending bitmap: acknowledge first, then merge new edges so a set wins.
  always_comb begin
    ack_mask_s = {N_REQ{1'b0}};
    if (out_valid_r && evt.out_ready) begin
      ack_mask_s = onehot(out_idx_r);
    end else begin
      ack_mask_s = {N_REQ{1'b0}};
    end
    pending_next_s = (pending_r & ~ack_mask_s) | edge_s;
    ovf_next_s     = ovf_r | (|(edge_s & pending_r & ~ack_mask_s));
    hold_s         = out_valid_r && !evt.out_ready;
  end

  // Pending, overflow and output registers; a stalled output is never preempted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_r   <= {N_REQ{1'b0}};
      ovf_r       <= 1'b0;
      out_idx_r   <= {IDX_W{1'b0}};
      out_valid_r <= 1'b0;
    end else if (clear) begin
      pending_r   <= {N_REQ{1'b0}};
      ovf_r       <= 1'b0;
      out_idx_r   <= {IDX_W{1'b0}};
      out_valid_r <= 1'b0;
    end else begin
      pending_r <= pending_next_s;
      ovf_r     <= ovf_next_s;
      if (!hold_s) begin
        out_valid_r <= |pending_next_s;
        out_idx_r   <= prio_idx(pending_next_s);
      end else begin
        out_valid_r <= out_valid_r;
        out_idx_r   <= out_idx_r;
      end
    end
  end

  assign evt.out_idx   = out_idx_r;
  assign evt.out_valid = out_valid_r;
  assign pending       = pending_r;
  assign ovf           = ovf_r;

endmodule

// File: tb/tb_req_encoder83.sv
// Directed scenarios plus random traffic, every cycle compared against a
// cycle-level reference model built from the edge/pending/handshake rules.
module tb_req_encoder83;
  import req_encoder83_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] req;
  logic       clear;
  logic [7:0] pending;
  logic       ovf;

  req_encoder83_if bus ();

  req_encoder83 dut (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req),
    .clear   (clear),
    .evt     (bus),
    .pending (pending),
    .ovf     (ovf)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state: req as sampled at the last three edges, plus outputs.
  logic [7:0] hist [3];
  logic [7:0] m_pend;
  logic       m_ovf;
  logic       m_valid;
  logic [2:0] m_idx;
  int         acked[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) hist[i] = 8'h00;
    m_pend  = 8'h00;
    m_ovf   = 1'b0;
    m_valid = 1'b0;
    m_idx   = 3'd0;
  endtask

  // One clock edge: an event on bit k fires when req[k] was high two edges ago
  // and low three edges ago.
  task automatic model_step();
    logic [7:0] ev;
    logic [7:0] p;
    ev = hist[1] & ~hist[2];
    if (clear) begin
      m_pend  = 8'h00;
      m_ovf   = 1'b0;
      m_valid = 1'b0;
      m_idx   = 3'd0;
    end else begin
      p = m_pend;
      if (m_valid && bus.out_ready) begin
        acked.push_back(int'(m_idx));
        p[m_idx] = 1'b0;
      end
      if ((p & ev) != 8'h00) m_ovf = 1'b1;
      p      = p | ev;
      m_pend = p;
      if (!(m_valid && !bus.out_ready)) begin
        m_valid = (p != 8'h00);
        m_idx   = (p == 8'h00) ? 3'd0 : 3'($clog2(int'(p) + 1) - 1);
      end
    end
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = req;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset_n) model_reset();
    else model_step();
    #1;
    check("out_idx",   32'(bus.out_idx),   32'(m_idx));
    check("out_valid", 32'(bus.out_valid), 32'(m_valid));
    check("pending",   32'(pending),       32'(m_pend));
    check("ovf",       32'(ovf),           32'(m_ovf));
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_valid(input string tag, input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      if (bus.out_valid) break;
      tick();
    end
    check(tag, 32'(bus.out_valid), 32'd1);
  endtask

  initial begin
    int nv;
    int exp_ord [3];
    exp_ord[0] = 7; exp_ord[1] = 2; exp_ord[2] = 0;

    reset_n = 1'b0;
    req = 8'h00;
    clear = 1'b0;
    bus.out_ready = 1'b1;
    model_reset();
    tick_n(3);
    check("rst_pending", 32'(pending), 32'h0);
    check("rst_ovf",     32'(ovf), 32'h0);
    check("rst_valid",   32'(bus.out_valid), 32'h0);
    check("rst_idx",     32'(bus.out_idx), 32'h0);
    reset_n = 1'b1;
    tick_n(2);

    // Single event on bit 5, held three cycles.
    req[5] = 1'b1;
    nv = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.out_valid) begin
        nv++;
        check("single_idx", 32'(bus.out_idx), 32'd5);
      end
      if (i == 2) req[5] = 1'b0;
    end
    check("single_count",   32'(nv), 32'd1);
    check("single_pending", 32'(pending), 32'h0);
    check("single_ovf",     32'(ovf), 32'h0);

    // Three simultaneous requests drain by priority.
    acked.delete();
    req = 8'h85;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i == 2) req = 8'h00;
    end
    check("prio_count", 32'(acked.size()), 32'd3);
    for (int k = 0; k < 3; k++)
      check("prio_order", (k < acked.size()) ? 32'(acked[k]) : 32'hFF, 32'(exp_ord[k]));
    check("prio_idle", 32'(bus.out_valid), 32'h0);

    // Backpressure: held index is not preempted by a higher-priority arrival.
    bus.out_ready = 1'b0;
    req[3] = 1'b1;
    wait_valid("bp_wait", 10);
    check("bp_idx", 32'(bus.out_idx), 32'd3);
    req[3] = 1'b0;
    tick_n(2);
    req[6] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("bp_hold", 32'(bus.out_idx), 32'd3);
    end
    bus.out_ready = 1'b1;
    tick();
    check("bp_next_valid", 32'(bus.out_valid), 32'd1);
    check("bp_next_idx",   32'(bus.out_idx), 32'd6);
    tick();
    req[6] = 1'b0;
    tick_n(3);

    // Set wins: a new bit-4 edge lands on the same edge as the bit-4 handshake.
    bus.out_ready = 1'b0;
    req[4] = 1'b1;
    wait_valid("sw_wait", 10);
    check("sw_idx", 32'(bus.out_idx), 32'd4);
    req[4] = 1'b0;
    tick_n(2);
    req[4] = 1'b1;
    tick_n(2);
    bus.out_ready = 1'b1;
    tick();
    check("sw_pending4", 32'(pending[4]), 32'd1);
    check("sw_ovf",      32'(ovf), 32'd0);
    check("sw_reemit",   32'(bus.out_idx), 32'd4);
    tick();
    bus.out_ready = 1'b0;

    // Overflow: second bit-4 edge while 4 is pending and stalled.
    req[4] = 1'b0;
    tick_n(2);
    req[4] = 1'b1;
    wait_valid("ovf_wait", 10);
    req[4] = 1'b0;
    tick_n(2);
    req[4] = 1'b1;
    tick_n(3);
    check("ovf_set",     32'(ovf), 32'd1);
    check("ovf_pending", 32'(pending), 32'h10);

    // Clear flushes everything, including an edge detected in the same cycle.
    bus.out_ready = 1'b1;
    tick_n(2);
    req = 8'h00;
    bus.out_ready = 1'b0;
    tick_n(3);
    req = 8'hA1;
    tick_n(4);
    check("clr_pre_pending", 32'(pending), 32'hA1);
    check("clr_pre_ovf",     32'(ovf), 32'd1);
    req = 8'h00;
    tick_n(2);
    req[1] = 1'b1;
    tick_n(2);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr_pending", 32'(pending), 32'h0);
    check("clr_ovf",     32'(ovf), 32'h0);
    check("clr_valid",   32'(bus.out_valid), 32'h0);
    tick_n(4);
    check("clr_lost", 32'(pending), 32'h0);
    req = 8'h00;
    tick_n(3);

    // Asynchronous reset mid-operation, released with req[1] held high.
    req[2] = 1'b1;
    wait_valid("arst_wait", 10);
    #3;
    reset_n = 1'b0;
    req = 8'h02;
    model_reset();
    #1;
    check("arst_valid",   32'(bus.out_valid), 32'h0);
    check("arst_idx",     32'(bus.out_idx), 32'h0);
    check("arst_pending", 32'(pending), 32'h0);
    check("arst_ovf",     32'(ovf), 32'h0);
    tick_n(2);
    reset_n = 1'b1;
    bus.out_ready = 1'b1;
    acked.delete();
    tick_n(8);
    check("arst_events", 32'(acked.size()), 32'd1);
    check("arst_evidx", (acked.size() > 0) ? 32'(acked[0]) : 32'hFF, 32'd1);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0) req = 8'($urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      clear = ($urandom_range(0, 31) == 0);
      tick();
    end
    clear = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
